ddr2_sys_st_timing_fifo_adt: RTL and testbench

// - Avalon-ST timing adapter, next generation: bridges a source with no usable backpressure
//   to a sink that deasserts ready, absorbing stalls in a DEPTH-entry FIFO.
// - Generalised data width; 1-cycle registered latency; advisory almost-full ready upstream.
// - Sticky overflow flag instead of a simulation-only message.
// - Sits between a streaming master port and its consumer in the DDR2 system.

---
 rtl/ddr2_sys_st_timing_fifo_adt.sv | 113 +++++++++++
 tb/tb_ddr2_sys_st_timing_fifo_adt.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ddr2_sys_st_timing_fifo_adt.sv
// ddr2_sys_st_timing_fifo_adt
// Avalon-ST timing adapter: takes beats from a source that ignores backpressure
// and holds them in a DEPTH-entry show-ahead FIFO until the sink accepts them.
// in_ready is advisory only (almost-full). A beat that arrives when the FIFO
// cannot take it is dropped, and the sticky overflow flag is set.
// Optional build macro ST_TIMING_FIFO_DROP_CNT_EN: when defined, drop_cnt is a
// saturating 16-bit count of dropped beats. When undefined, drop_cnt is tied to 0.
module ddr2_sys_st_timing_fifo_adt #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  input  logic                     clr_overflow,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  // in_ready holds while (DEPTH - level) > AF_MARGIN, i.e. level < DEPTH - AF_MARGIN
  localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - AF_MARGIN);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_overflow;

  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake decode from the registered occupancy
  always_comb begin
    w_pop  = (r_level != '0) && out_ready;
    w_push = in_valid && ((r_level != FULL_LVL) || w_pop);
    w_drop = in_valid && !w_push;
  end

  // Payload storage; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_push && !reset)
      r_mem[r_wr_ptr] <= in_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow; a drop in the clear cycle wins
  always_ff @(posedge clk) begin
    if (reset)
      r_overflow <= 1'b0;
    else if (w_drop)
      r_overflow <= 1'b1;
    else if (clr_overflow)
      r_overflow <= 1'b0;
  end

`ifdef ST_TIMING_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating dropped-beat counter; clear restarts the count at this cycle's drop
  always_ff @(posedge clk) begin
    if (reset)
      r_drop_cnt <= '0;
    else if (clr_overflow)
      r_drop_cnt <= {15'd0, w_drop};
    else if (w_drop && (r_drop_cnt != '1))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  // Counter output
  always_comb drop_cnt = r_drop_cnt;
`else
  // No counter in this build
  always_comb drop_cnt = '0;
`endif

  // Output decode, all from registers
  always_comb begin
    level     = r_level;
    out_valid = (r_level != '0);
    out_data  = r_mem[r_rd_ptr];
    in_ready  = (r_level < AF_LVL);
    overflow  = r_overflow;
  end

endmodule

// File: tb/tb_ddr2_sys_st_timing_fifo_adt.sv
// Bench for ddr2_sys_st_timing_fifo_adt: directed and random stimulus compared
// against a queue-based reference model after every clock edge.
module tb_ddr2_sys_st_timing_fifo_adt;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned AF_MARGIN = 2;
  localparam int unsigned AW        = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              clr_overflow;
  logic              overflow;
  logic [AW:0]       level;
  logic [15:0]       drop_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  bit                m_ov;
  int                m_cnt;

  always #5 clk = ~clk;

  ddr2_sys_st_timing_fifo_adt #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_MARGIN(AF_MARGIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .clr_overflow(clr_overflow),
    .overflow    (overflow),
    .level       (level),
    .drop_cnt    (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":level"},     32'(level),     32'(q.size()));
    chk({ph, ":out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({ph, ":in_ready"},  32'(in_ready),  32'((DEPTH - q.size()) > AF_MARGIN));
    chk({ph, ":overflow"},  32'(overflow),  32'(m_ov));
    chk({ph, ":drop_cnt"},  32'(drop_cnt),  32'(m_cnt));
    if (q.size() != 0)
      chk({ph, ":out_data"}, 32'(out_data), 32'(q[0]));
  endtask

  // One clock: apply inputs, advance model by the FIFO rules, check after the edge
  task automatic cycle(input string ph, input bit v, input logic [DATA_W-1:0] d,
                       input bit r, input bit clr, input bit rst);
    bit pop, push, drop;
    reset = rst; in_valid = v; in_data = d; out_ready = r; clr_overflow = clr;
    @(posedge clk);
    pop  = (q.size() > 0) && r;
    push = v && ((q.size() < DEPTH) || pop);
    drop = v && !push;
    if (rst) begin
      q.delete();
      m_ov  = 0;
      m_cnt = 0;
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      if (drop) m_ov = 1;
      else if (clr) m_ov = 0;
`ifdef ST_TIMING_FIFO_DROP_CNT_EN
      if (clr) m_cnt = drop ? 1 : 0;
      else if (drop && m_cnt < 65535) m_cnt++;
`endif
    end
    #1;
    check_all(ph);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    m_ov = 0; m_cnt = 0;

    // Reset
    cycle("reset", 1, 8'h33, 0, 0, 1);
    cycle("reset", 0, 8'h00, 0, 0, 1);

    // Pass-through of 0x01..0x14 with sink always ready
    for (int i = 1; i <= 20; i++) begin
      cycle("pass", 1, 8'(i), 1, 0, 0);
      chk("pass:lvl_le1", 32'(level <= 1), 32'd1);
    end
    cycle("pass_tail", 0, 8'h00, 1, 0, 0);

    // Fill with sink stalled
    for (int i = 0; i < 8; i++) cycle("fill", 1, 8'h10 + 8'(i), 0, 0, 0);

    // Overflow: full, stalled, push 0xAA
    cycle("ovf", 1, 8'hAA, 0, 0, 0);

    // Full with simultaneous pop: accepted, level stays at DEPTH
    cycle("fullpop", 1, 8'h55, 1, 0, 0);

    // Drain; model order excludes 0xAA
    for (int i = 0; i < 10; i++) cycle("drain", 0, 8'h00, 1, 0, 0);

    // Clear overflow, then drop and clear in the same cycle (set wins)
    cycle("clr", 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle("refill", 1, 8'h60 + 8'(i), 0, 0, 0);
    cycle("drop_clr", 1, 8'hBB, 0, 1, 0);
    cycle("clr2", 0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 8; i++) cycle("drain2", 0, 8'h00, 1, 0, 0);

    // Wrap: 3 x (push 6, pop 6)
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) cycle("wrap_push", 1, 8'(k * 16 + i + 8'h80), 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle("wrap_pop", 0, 8'h00, 1, 0, 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", bit'($urandom_range(0, 1)), 8'($urandom()),
            bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 15) == 0), 0);

    // Reset mid-operation at level 5
    cycle("pre_rst", 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle("pre_rst", 0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 5; i++) cycle("lvl5", 1, 8'hC0 + 8'(i), 0, 0, 0);
    chk("lvl5:level", 32'(level), 32'd5);
    cycle("midrst", 1, 8'hEE, 0, 0, 1);
    chk("midrst:level0", 32'(level), 32'd0);
    cycle("post_rst", 1, 8'h42, 1, 0, 0);
    cycle("post_rst", 0, 8'h00, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
